// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for a show-ahead FIFO. Pops WIDTH-bit words whenever
//   they are available and packs RATIO consecutive words into one wide beat,
//   first-popped word in the LSBs. The beat is presented on a registered
//   valid/ready output; up to RATIO-1 further words may be accumulated while
//   a beat is held.
//
// Ports
//   clk         clock, all state changes on posedge
//   rst         synchronous active-high reset
//   fifo_dout   FIFO head word, valid whenever fifo_empty=0 (no read latency)
//   fifo_empty  FIFO empty flag
//   fifo_r      pop strobe to the FIFO (combinational)
//   flush       synchronous discard of the partial beat and the held beat
//   out_data    assembled beat (registered)
//   out_vld     beat valid (registered)
//   out_rdy     consumer accepts the beat when out_vld & out_rdy at a posedge
//   busy        partial beat in progress or beat held
module fifo_rd_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_r,
  input  logic                   flush,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   busy
);

  logic                   last;      // next pop completes a beat
  logic                   partial;   // words accumulated for an unfinished beat
  logic                   slot_free; // output register can take a new beat
  logic                   pop;
  logic [WIDTH*RATIO-1:0] beat;      // beat formed if the current head is the last word

  assign slot_free = !out_vld | out_rdy;

  // out_rdy reaches fifo_r through a single AND/OR level so a stalled last
  // word is released in the same cycle the consumer becomes ready.
  assign fifo_r = !rst & !flush & !fifo_empty & (!last | slot_free);
  assign pop    = fifo_r;
  assign busy   = partial | out_vld;

  generate
    if (RATIO == 1) begin : g_direct
      // Every word is a complete beat; no accumulator or counter needed.
      assign last    = 1'b1;
      assign partial = 1'b0;
      assign beat    = fifo_dout;
    end else begin : g_pack
      localparam int unsigned CW = $clog2(RATIO);
      localparam int unsigned AW = WIDTH * (RATIO - 1);

      logic [CW-1:0] cnt;
      logic [AW-1:0] acc;

      assign last    = (cnt == CW'(RATIO - 1));
      assign partial = (cnt != '0);
      assign beat    = {fifo_dout, acc};

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          cnt <= '0;
          acc <= '0;
        end else if (pop) begin
          if (last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            for (int unsigned i = 0; i < RATIO - 1; i++) begin
              if (cnt == CW'(i)) begin
                acc[i*WIDTH +: WIDTH] <= fifo_dout;
              end
            end
          end
        end
      end
    end
  endgenerate

  // Output register. A last-word pop takes priority over the handshake so a
  // delivered beat is replaced by the new one without a bubble; otherwise a
  // handshake simply empties the slot. out_data is left untouched on flush
  // and on delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
    end else if (pop && last) begin
      out_data <= beat;
      out_vld  <= 1'b1;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a RATIO=4 instance and a RATIO=1 instance,
// each fed from a queue acting as the show-ahead FIFO and compared every
// cycle against a queue-based model of the packing rules, plus directed
// checks on the sequence of beats the consumer actually accepted.
module tb_fifo_rd_packer;
  localparam int unsigned RA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RATIO=4 harness
  logic        rst, flush, fifo_empty, fifo_r, out_vld, out_rdy, busy;
  logic [7:0]  fifo_dout;
  logic [31:0] out_data;

  // RATIO=1 harness
  logic        rst1, flush1, fifo_empty1, fifo_r1, out_vld1, out_rdy1, busy1;
  logic [7:0]  fifo_dout1, out_data1;

  fifo_rd_packer #(.WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_r(fifo_r), .flush(flush), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .busy(busy)
  );

  fifo_rd_packer #(.WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst1), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
    .fifo_r(fifo_r1), .flush(flush1), .out_data(out_data1), .out_vld(out_vld1),
    .out_rdy(out_rdy1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  // FIFO contents and model state
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  part[$];      // words gathered for the unfinished RATIO=4 beat
  logic        ma_vld;
  logic [31:0] ma_data;
  logic        mb_vld;
  logic [7:0]  mb_data;

  // beats accepted by the consumer (observed on the DUT outputs)
  logic [31:0] obs_a[$];
  logic [7:0]  obs_b[$];
  logic [7:0]  words_b[$];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // One clock cycle: present FIFO heads, check outputs against the model,
  // record accepted beats, then advance the model across the posedge.
  task automatic cycle();
    logic       pa, pb;
    logic [7:0] w;
    fifo_empty  = (qa.size() == 0);
    fifo_dout   = fifo_empty ? 8'hEE : qa[0];
    fifo_empty1 = (qb.size() == 0);
    fifo_dout1  = fifo_empty1 ? 8'hEE : qb[0];
    #2;
    // A word is taken when there is one, nothing blocks, and a completed
    // beat would have somewhere to go.
    pa = !rst && !flush && (qa.size() != 0) &&
         ((part.size() != RA - 1) || !ma_vld || out_rdy);
    pb = !rst1 && (qb.size() != 0) && (!mb_vld || out_rdy1);

    chk("a_fifo_r",   32'(fifo_r),  32'(pa));
    chk("a_out_vld",  32'(out_vld), 32'(ma_vld));
    chk("a_out_data", out_data,     ma_data);
    chk("a_busy",     32'(busy),    32'((part.size() != 0) || ma_vld));
    chk("b_fifo_r",   32'(fifo_r1),  32'(pb));
    chk("b_out_vld",  32'(out_vld1), 32'(mb_vld));
    chk("b_out_data", 32'(out_data1), 32'(mb_data));
    chk("b_busy",     32'(busy1),    32'(mb_vld));

    if (out_vld && out_rdy && !rst)     obs_a.push_back(out_data);
    if (out_vld1 && out_rdy1 && !rst1)  obs_b.push_back(out_data1);

    @(posedge clk);
    #1;

    if (rst) begin
      part.delete();
      ma_vld  = 1'b0;
      ma_data = '0;
    end else if (flush) begin
      part.delete();
      ma_vld = 1'b0;
    end else begin
      if (ma_vld && out_rdy) ma_vld = 1'b0;
      if (pa) begin
        w = qa.pop_front();
        part.push_back(w);
        if (part.size() == RA) begin
          ma_data = '0;
          foreach (part[k]) ma_data = ma_data | (32'(part[k]) << (8 * k));
          ma_vld = 1'b1;
          part.delete();
        end
      end
    end

    if (rst1) begin
      mb_vld  = 1'b0;
      mb_data = '0;
    end else begin
      if (mb_vld && out_rdy1) mb_vld = 1'b0;
      if (pb) begin
        mb_data = qb.pop_front();
        mb_vld  = 1'b1;
      end
    end
  endtask

  initial begin
    int rst_left;
    bit did_rst;

    rst = 1'b1;  flush = 1'b0;  out_rdy = 1'b1;  fifo_empty = 1'b1;  fifo_dout = '0;
    rst1 = 1'b1; flush1 = 1'b0; out_rdy1 = 1'b1; fifo_empty1 = 1'b1; fifo_dout1 = '0;
    ma_vld = 1'b0; ma_data = '0; mb_vld = 1'b0; mb_data = '0;
    @(posedge clk);
    #1;

    // Reset holds off popping even with a word at the FIFO head.
    qa.push_back(8'h5A);
    qb.push_back(8'h5A);
    repeat (3) cycle();
    chk("rst_a_head_kept", 32'(qa.size()), 32'd1);
    qa.delete();
    qb.delete();
    rst = 1'b0;
    rst1 = 1'b0;
    cycle();

    // Basic pack with the consumer always ready.
    obs_a.delete();
    qa.push_back(8'h11); qa.push_back(8'h22); qa.push_back(8'h33); qa.push_back(8'h44);
    repeat (6) cycle();
    chk("basic_beats", 32'(obs_a.size()), 32'd1);
    if (obs_a.size() >= 1) chk("basic_beat0", obs_a[0], 32'h44332211);

    // Backpressure: one beat held, three more words gathered, then stall.
    obs_a.delete();
    out_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) qa.push_back(8'(i));
    repeat (10) cycle();
    chk("bp_stalled_head", 32'(qa.size()), 32'd1);
    out_rdy = 1'b1;
    repeat (3) cycle();
    chk("bp_beats", 32'(obs_a.size()), 32'd2);
    if (obs_a.size() >= 2) begin
      chk("bp_beat0", obs_a[0], 32'h04030201);
      chk("bp_beat1", obs_a[1], 32'h08070605);
    end

    // Sparse input, words arriving three cycles apart.
    obs_a.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(8'hA1 + 8'(i));
      repeat (3) cycle();
    end
    chk("sparse_beats", 32'(obs_a.size()), 32'd1);
    if (obs_a.size() >= 1) chk("sparse_beat0", obs_a[0], 32'hA4A3A2A1);

    // Flush mid-beat discards the two words already gathered.
    obs_a.delete();
    qa.push_back(8'hAA); qa.push_back(8'hBB);
    repeat (2) cycle();
    for (int i = 1; i <= 4; i++) qa.push_back(8'(i));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (6) cycle();
    chk("flush_beats", 32'(obs_a.size()), 32'd1);
    if (obs_a.size() >= 1) chk("flush_beat0", obs_a[0], 32'h04030201);

    // RATIO=1 streaming, with a reset right after the fifth accepted beat.
    obs_b.delete();
    for (int i = 0; i < 16; i++) begin
      words_b.push_back(8'($urandom));
      qb.push_back(words_b[i]);
    end
    rst_left = 0;
    did_rst  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rst1 = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      cycle();
      if (!did_rst && obs_b.size() == 5) begin
        did_rst  = 1'b1;
        rst_left = 2;
      end
    end
    rst1 = 1'b0;
    // The sixth word was popped into the output register and lost to reset.
    chk("r1_beats", 32'(obs_b.size()), 32'd15);
    for (int i = 0; i < 15; i++) begin
      if (i < obs_b.size()) chk("r1_beat", 32'(obs_b[i]), 32'(words_b[(i < 5) ? i : i + 1]));
    end

    // Randomized traffic on both instances: gaps, backpressure, flushes, resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 6) qa.push_back(8'($urandom));
      if ($urandom_range(0, 9) < 6) qb.push_back(8'($urandom));
      out_rdy  = ($urandom_range(0, 3) != 0);
      out_rdy1 = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      rst      = ($urandom_range(0, 80) == 0);
      rst1     = ($urandom_range(0, 80) == 0);
      cycle();
    end
    rst = 1'b0; rst1 = 1'b0; flush = 1'b0; out_rdy = 1'b1; out_rdy1 = 1'b1;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
